mole_hit_judge: RTL and testbench

//  Consumer end of the mole-spawn path: takes the lit-mole vector driven by the LED randomiser and the debounced

---
 rtl/mole_pkg.sv | 19 +
 rtl/mole_hit_judge_if.sv | 32 +++
 rtl/slot_popcount.sv | 17 +
 rtl/mole_hit_judge.sv | 137 +++++++++++++
 tb/tb_mole_hit_judge.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole hit judge.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mole_pkg;

   localparam int SLOTS_DEF = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } game_state_t;

   // Points per hit at a difficulty level: level 0..3 -> 1..4.
   function automatic logic [2:0] points(input logic [1:0] level);
      return {1'b0, level} + 3'd1;
   endfunction

endpackage

// File: rtl/mole_hit_judge_if.sv
// Bundle between randomiser/debouncers (master side) and the hit judge (slave side).
// Latency: n/a (wiring only).
// Backpressure: none; levels and pulses are sampled every cycle.
// Ports: mole_leds/switches/restart/level into the judge; mole_clear, pulse flags,
//        score, miss_count and game state out of the judge.
interface mole_hit_judge_if #(
   parameter int SLOTS   = 18,
   parameter int SCORE_W = 10
);
   logic [SLOTS-1:0]   mole_leds;
   logic [SLOTS-1:0]   switches;
   logic               restart;
   logic [1:0]         level;
   logic [SLOTS-1:0]   mole_clear;
   logic               hit;
   logic               miss;
   logic               false_whack;
   logic [SCORE_W-1:0] score;
   logic [2:0]         miss_count;
   logic               playing;
   logic               game_over;

   modport master (
      output mole_leds, switches, restart, level,
      input  mole_clear, hit, miss, false_whack, score, miss_count, playing, game_over
   );

   modport slave (
      input  mole_leds, switches, restart, level,
      output mole_clear, hit, miss, false_whack, score, miss_count, playing, game_over
   );
endinterface

// File: rtl/slot_popcount.sv
// Counts set bits of a per-slot vector.
// Latency: combinational.
// Backpressure: n/a.
// Ports: bits (N-bit vector in), count (5-bit population count out).
module slot_popcount #(
   parameter int N = 18
) (
   input  logic [N-1:0] bits,
   output logic [4:0]   count
);
   always_comb begin
      count = 5'd0;
      for (int i = 0; i < N; i++) begin
         count = count + 5'(bits[i]);
      end
   end
endmodule

// File: rtl/mole_hit_judge.sv
// Judges switch toggles against lit moles as hits / false whacks / misses; keeps score and game state.
// Latency: inputs driven after edge t are reflected in pulses, score and mask after edge t+1.
// Backpressure: none; every cycle is judged while playing.
// Ports: clk, reset_n (async active-low), bus (mole_hit_judge_if.slave).
module mole_hit_judge
   import mole_pkg::*;
#(
   parameter int SLOTS      = SLOTS_DEF,
   parameter int SCORE_W    = 10,
   parameter int MAX_SCORE  = 999,
   parameter int MAX_MISSES = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   mole_hit_judge_if.slave  bus
);
   localparam int SUM_W = SCORE_W + 2;

   game_state_t        state_q, state_d;
   logic [SLOTS-1:0]   sw_q, mole_q, hit_mask_q, hit_mask_d;
   logic [SCORE_W-1:0] score_q, score_d, score_clamped;
   logic [2:0]         mc_q, mc_d;
   logic               hit_q, miss_q, fw_q, hit_d, miss_d, fw_d;

   logic [SLOTS-1:0]   toggle, hit_v, fw_v, miss_v;
   logic [4:0]         nh, nf, nm, mc_sum;
   logic [6:0]         gain;
   logic signed [SUM_W-1:0] score_sum;

   // Any switch edge is a whack, regardless of direction.
   assign toggle = bus.switches ^ sw_q;
   assign hit_v  = toggle & bus.mole_leds & ~hit_mask_q;
   assign fw_v   = toggle & ~bus.mole_leds;
   assign miss_v = mole_q & ~bus.mole_leds & ~hit_mask_q;

   slot_popcount #(.N(SLOTS)) u_nh (.bits(hit_v),  .count(nh));
   slot_popcount #(.N(SLOTS)) u_nf (.bits(fw_v),   .count(nf));
   slot_popcount #(.N(SLOTS)) u_nm (.bits(miss_v), .count(nm));

   assign gain      = 7'(nh) * 7'(points(bus.level));
   assign score_sum = $signed(SUM_W'(score_q)) + $signed(SUM_W'(gain)) - $signed(SUM_W'(nf));
   assign mc_sum    = 5'(mc_q) + nm;

   always_comb begin
      score_clamped = score_sum[SCORE_W-1:0];
      if (score_sum < 0)
         score_clamped = '0;
      else if (score_sum > $signed(SUM_W'(MAX_SCORE)))
         score_clamped = SCORE_W'(MAX_SCORE);
   end

   always_comb begin
      state_d    = state_q;
      hit_mask_d = hit_mask_q;
      score_d    = score_q;
      mc_d       = mc_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      fw_d       = 1'b0;
      case (state_q)
         IDLE: begin
            hit_mask_d = '0;
            if (bus.restart) begin
               state_d = PLAY;
               score_d = '0;
               mc_d    = '0;
            end
         end
         PLAY: begin
            if (bus.restart) begin
               score_d    = '0;
               mc_d       = '0;
               hit_mask_d = '0;
            end else begin
               hit_d   = |hit_v;
               miss_d  = |miss_v;
               fw_d    = |fw_v;
               score_d = score_clamped;
               // Masking with the current LEDs drops the bit of any mole that fell.
               hit_mask_d = (hit_mask_q | hit_v) & bus.mole_leds;
               if (mc_sum >= 5'(MAX_MISSES)) begin
                  mc_d       = 3'(MAX_MISSES);
                  state_d    = OVER;
                  hit_mask_d = '0;
               end else begin
                  mc_d = mc_sum[2:0];
               end
            end
         end
         OVER: begin
            hit_mask_d = '0;
            if (bus.restart) begin
               state_d = PLAY;
               score_d = '0;
               mc_d    = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            hit_mask_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sw_q       <= '0;
         mole_q     <= '0;
         hit_mask_q <= '0;
         score_q    <= '0;
         mc_q       <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         fw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sw_q       <= bus.switches;
         mole_q     <= bus.mole_leds;
         hit_mask_q <= hit_mask_d;
         score_q    <= score_d;
         mc_q       <= mc_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         fw_q       <= fw_d;
      end
   end

   assign bus.mole_clear  = hit_mask_q;
   assign bus.hit         = hit_q;
   assign bus.miss        = miss_q;
   assign bus.false_whack = fw_q;
   assign bus.score       = score_q;
   assign bus.miss_count  = mc_q;
   assign bus.playing     = (state_q == PLAY);
   assign bus.game_over   = (state_q == OVER);
endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed table-driven bench for mole_hit_judge plus hand sequences for saturation and async reset.
// Latency: checks one clock after each applied vector.
// Backpressure: n/a.
module tb_mole_hit_judge;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   mole_hit_judge_if #(.SLOTS(18), .SCORE_W(10)) bus ();

   mole_hit_judge dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [17:0] leds;
      logic [17:0] sw;
      logic        rst;
      logic [1:0]  lvl;
      logic [17:0] clr;
      logic        h;
      logic        m;
      logic        f;
      logic [9:0]  sc;
      logic [2:0]  mc;
      logic        pl;
      logic        ov;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [17:0] b(input int n);
      logic [17:0] one;
      one = 18'd1;
      return one << n;
   endfunction

   function automatic logic [35:0] pk(input logic [17:0] clr, input logic h, input logic m,
                                      input logic f, input logic [9:0] sc, input logic [2:0] mc,
                                      input logic pl, input logic ov);
      return {clr, h, m, f, sc, mc, pl, ov};
   endfunction

   function automatic logic [35:0] obs();
      return pk(bus.mole_clear, bus.hit, bus.miss, bus.false_whack, bus.score,
                bus.miss_count, bus.playing, bus.game_over);
   endfunction

   task automatic check(input string name, input logic [35:0] exp);
      logic [35:0] act;
      act = obs();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {clr,h,m,f,score,mc,pl,ov}=%h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [17:0] leds, input logic [17:0] sw, input logic rst,
                      input logic [1:0] lvl, input logic [17:0] clr, input logic h,
                      input logic m, input logic f, input logic [9:0] sc,
                      input logic [2:0] mc, input logic pl, input logic ov);
      vec_t v;
      v.leds = leds; v.sw = sw; v.rst = rst; v.lvl = lvl; v.clr = clr;
      v.h = h; v.m = m; v.f = f; v.sc = sc; v.mc = mc; v.pl = pl; v.ov = ov;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [17:0] s;
      logic [17:0] s2;
      logic [17:0] sw;
      int          e;

      // Switch 3 held up through reset and idle must never score.
      add(18'd0, b(3), 1'b0, 2'd0, 18'd0, 0, 0, 0, 10'd0, 3'd0, 0, 0);
      add(18'd0, b(3), 1'b1, 2'd0, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      add(18'd0, b(3), 1'b0, 2'd0, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      // Level 2 hit on slot 5, then a repeat whack on the same mole is ignored.
      add(b(5), b(3),        1'b0, 2'd2, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      add(b(5), b(3) | b(5), 1'b0, 2'd2, b(5),  1, 0, 0, 10'd3, 3'd0, 1, 0);
      add(b(5), b(3),        1'b0, 2'd2, b(5),  0, 0, 0, 10'd3, 3'd0, 1, 0);
      add(18'd0, b(3),       1'b0, 2'd2, 18'd0, 0, 0, 0, 10'd3, 3'd0, 1, 0);
      // Restart mid-game, then a false whack at score 0 stays floored.
      add(18'd0, b(3),        1'b1, 2'd2, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      add(18'd0, b(3) | b(7), 1'b0, 2'd2, 18'd0, 0, 0, 1, 10'd0, 3'd0, 1, 0);
      // Build score to 5 (level 3 hit + level 0 hit), then false whack -> 4.
      add(b(5), b(3) | b(7),        1'b0, 2'd3, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      add(b(5), b(3) | b(5) | b(7), 1'b0, 2'd3, b(5),  1, 0, 0, 10'd4, 3'd0, 1, 0);
      add(b(5) | b(6), b(3) | b(5) | b(7),        1'b0, 2'd0, b(5),        0, 0, 0, 10'd4, 3'd0, 1, 0);
      add(b(5) | b(6), b(3) | b(5) | b(6) | b(7), 1'b0, 2'd0, b(5) | b(6), 1, 0, 0, 10'd5, 3'd0, 1, 0);
      add(b(5) | b(6), b(3) | b(5) | b(6),        1'b0, 2'd0, b(5) | b(6), 0, 0, 1, 10'd4, 3'd0, 1, 0);
      add(18'd0,       b(3) | b(5) | b(6),        1'b0, 2'd0, 18'd0,       0, 0, 0, 10'd4, 3'd0, 1, 0);
      // Five unhit drops of mole 2 end the game.
      for (int k = 1; k <= 5; k++) begin
         add(b(2),  b(3) | b(5) | b(6), 1'b0, 2'd0, 18'd0, 0, 0, 0, 10'd4, 3'(k - 1), 1, 0);
         add(18'd0, b(3) | b(5) | b(6), 1'b0, 2'd0, 18'd0, 0, 1, 0, 10'd4, 3'(k), (k < 5), (k == 5));
      end
      s = b(3) | b(5) | b(6) | b(7);
      // Whack while over: frozen. Restart -> play with clears.
      add(b(5),  s, 1'b0, 2'd0, 18'd0, 0, 0, 0, 10'd4, 3'd5, 0, 1);
      add(18'd0, s, 1'b1, 2'd0, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      // Same cycle: 3 hits at level 3, 1 false whack, 1 miss -> +11.
      s2 = s ^ b(0) ^ b(1) ^ b(4) ^ b(10);
      add(b(0) | b(1) | b(4) | b(9), s,  1'b0, 2'd3, 18'd0, 0, 0, 0, 10'd0, 3'd0, 1, 0);
      add(b(0) | b(1) | b(4),        s2, 1'b0, 2'd3, b(0) | b(1) | b(4), 1, 1, 1, 10'd11, 3'd1, 1, 0);
      add(18'd0,                     s2, 1'b0, 2'd3, 18'd0, 0, 0, 0, 10'd11, 3'd1, 1, 0);

      bus.mole_leds = 18'd0;
      bus.switches  = b(3);
      bus.restart   = 1'b0;
      bus.level     = 2'd0;
      reset_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", pk(18'd0, 0, 0, 0, 10'd0, 3'd0, 0, 0));
      reset_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         bus.mole_leds = vq[i].leds;
         bus.switches  = vq[i].sw;
         bus.restart   = vq[i].rst;
         bus.level     = vq[i].lvl;
         tick();
         check($sformatf("vec%0d", i), pk(vq[i].clr, vq[i].h, vq[i].m, vq[i].f, vq[i].sc,
                                            vq[i].mc, vq[i].pl, vq[i].ov));
      end

      // Two hits per round at level 3 (+8) from 11: reaches 995, then saturates at 999.
      sw = s2;
      e  = 11;
      bus.level = 2'd3;
      for (int i = 0; i < 125; i++) begin
         bus.mole_leds = b(12) | b(13);
         tick();
         sw = sw ^ b(12) ^ b(13);
         bus.switches = sw;
         tick();
         e = (e + 8 > 999) ? 999 : e + 8;
         check($sformatf("sat_hit%0d", i), pk(b(12) | b(13), 1, 0, 0, 10'(e), 3'd1, 1, 0));
         bus.mole_leds = 18'd0;
         tick();
      end

      // Asynchronous reset mid-game, away from any clock edge.
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset", pk(18'd0, 0, 0, 0, 10'd0, 3'd0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
